// File: rtl/if_bus_arbiter.sv
// if_bus_arbiter
// Round-robin arbiter and access sequencer that shares the single register
// access port of the interfaces block among four internal requesters.
// Only one single-word read or write is in flight at a time. dev_cs is held
// until the device acknowledges. A watchdog aborts an access that stalls.
//
// Handshake: a requester raises req_cs[i] as a level and keeps we/addr/wdata
// stable. The request is sampled only while the sequencer is idle. Completion
// is a one-cycle pulse on req_ready[i]. req_rdata and req_error are valid
// with that pulse and hold until the next completion. The requester drops
// req_cs[i] in the cycle after the pulse. On the device side, dev_cs stays
// high with stable dev_we/dev_addr/dev_wdata until dev_ready is seen. That
// cycle's dev_rdata is the read data.
//
// Ports:
//   clk, areset (async, active-low)
//   req_cs[3:0], req_we[3:0], req_addr[31:0] (8b/req), req_wdata[127:0] (32b/req)
//   req_ready[3:0], req_rdata[31:0], req_error, grant[3:0]
//   dev_cs, dev_we, dev_addr[7:0], dev_wdata[31:0], dev_ready, dev_rdata[31:0]
module if_bus_arbiter #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERROR_DATA     = 32'hdeadbeef
) (
  input  logic         clk,
  input  logic         areset,
  input  logic [3:0]   req_cs,
  input  logic [3:0]   req_we,
  input  logic [31:0]  req_addr,
  input  logic [127:0] req_wdata,
  output logic [3:0]   req_ready,
  output logic [31:0]  req_rdata,
  output logic         req_error,
  output logic [3:0]   grant,
  output logic         dev_cs,
  output logic         dev_we,
  output logic [7:0]   dev_addr,
  output logic [31:0]  dev_wdata,
  input  logic         dev_ready,
  input  logic [31:0]  dev_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [15:0] LP_TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [1:0]  r_last_grant;
  logic [1:0]  r_owner;
  logic [15:0] r_timer;
  logic [3:0]  r_req_ready;
  logic [31:0] r_req_rdata;
  logic        r_req_error;
  logic [3:0]  r_grant;
  logic        r_dev_cs;
  logic        r_dev_we;
  logic [7:0]  r_dev_addr;
  logic [31:0] r_dev_wdata;

  logic        w_found;
  logic [1:0]  w_win_idx;
  logic [1:0]  w_idx;

  // Cyclic search starting just after the last owner. The previous owner
  // is examined last (offset 4 wraps to offset 0).
  always_comb begin
    w_found   = 1'b0;
    w_win_idx = 2'd0;
    w_idx     = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      w_idx = r_last_grant + 2'(i);
      if (!w_found && req_cs[w_idx]) begin
        w_found   = 1'b1;
        w_win_idx = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 2'd3;
      r_owner      <= 2'd0;
      r_timer      <= 16'd0;
      r_req_ready  <= 4'd0;
      r_req_rdata  <= 32'd0;
      r_req_error  <= 1'b0;
      r_grant      <= 4'd0;
      r_dev_cs     <= 1'b0;
      r_dev_we     <= 1'b0;
      r_dev_addr   <= 8'd0;
      r_dev_wdata  <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_owner     <= w_win_idx;
            r_grant     <= 4'b0001 << w_win_idx;
            r_dev_cs    <= 1'b1;
            r_dev_we    <= req_we[w_win_idx];
            r_dev_addr  <= req_addr[{w_win_idx, 3'b000} +: 8];
            r_dev_wdata <= req_wdata[{w_win_idx, 5'b00000} +: 32];
            r_timer     <= 16'd0;
            r_state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // An acknowledge in the same cycle as the timeout still wins.
          if (dev_ready) begin
            r_req_rdata <= dev_rdata;
            r_req_error <= 1'b0;
            r_dev_cs    <= 1'b0;
            r_req_ready <= r_grant;
            r_state     <= ST_DONE;
          end else if (r_timer == LP_TIMER_LAST) begin
            r_req_rdata <= ERROR_DATA;
            r_req_error <= 1'b1;
            r_dev_cs    <= 1'b0;
            r_req_ready <= r_grant;
            r_state     <= ST_DONE;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        ST_DONE: begin
          r_req_ready  <= 4'd0;
          r_last_grant <= r_owner;
          r_grant      <= 4'd0;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign req_rdata = r_req_rdata;
  assign req_error = r_req_error;
  assign grant     = r_grant;
  assign dev_cs    = r_dev_cs;
  assign dev_we    = r_dev_we;
  assign dev_addr  = r_dev_addr;
  assign dev_wdata = r_dev_wdata;

endmodule

// File: doc/if_bus_arbiter.md
# if_bus_arbiter

Round-robin arbiter and access sequencer that shares the single register-access port of the external interfaces block among four internal requesters. Candidates are the NTP engines, the control CPU bridge, the statistics collector and the PPS/time sync logic. It serialises single-word read/write accesses, holds the device chip-select until the device acknowledges, and aborts stalled accesses with a watchdog. It sits between the requesters and the `interfaces` block, in the same clock domain.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 255: the number of ACCESS cycles without `dev_ready` before the access aborts. The legal range is 1..65535.
- `ERROR_DATA`, default 32'hdeadbeef: the value returned on `req_rdata` when an access aborts.

Ports:
- `clk` input 1: the single clock. All logic is on its rising edge.
- `areset` input 1: asynchronous reset, active-low.
- `req_cs` input 4: per-requester access request (level). Bit i belongs to requester i.
- `req_we` input 4: per-requester write enable. 1 means write, 0 means read.
- `req_addr` input 32: packed addresses. Requester i uses `[8i+7:8i]`.
- `req_wdata` input 128: packed write data. Requester i uses `[32i+31:32i]`.
- `req_ready` output 4: one-cycle completion pulse, on the owner's bit only.
- `req_rdata` output 32: read data. It is shared by all requesters and valid when any `req_ready` bit is high.
- `req_error` output 1: timeout flag. It is valid together with `req_ready`.
- `grant` output 4: one-hot current owner. It is 0 when no access is in progress.
- `dev_cs` output 1: device chip-select.
- `dev_we` output 1: device write enable.
- `dev_addr` output 8: device address.
- `dev_wdata` output 32: device write data.
- `dev_ready` input 1: device acknowledge.
- `dev_rdata` input 32: device read data. It is sampled when `dev_ready` is high.

## Operation

- All outputs are registered.
- Reset values:
  - All outputs are 0.
  - The FSM is in IDLE.
  - The timer is 0.
  - `last_grant` is 3, so requester 0 has the highest priority after reset.
- FSM states:
  - **IDLE**
    - If any `req_cs` bit is high, the winner is the first set bit searched cyclically from `last_grant+1`.
    - Latch the winner's `we`, `addr` and `wdata` into the `dev_*` registers.
    - Set `dev_cs=1`, set `grant` to the winner's one-hot, clear the timer, and go to ACCESS.
    - Otherwise stay in IDLE.
  - **ACCESS**
    - `dev_cs` and the `dev_*` signals are held stable.
    - If `dev_ready=1`:
      - Capture `dev_rdata` into `req_rdata`.
      - Set `req_error=0`.
      - Set `dev_cs=0` and go to DONE.
    - Else, if timer == `TIMEOUT_CYCLES-1`:
      - Set `req_rdata=ERROR_DATA` and `req_error=1`.
      - Set `dev_cs=0` and go to DONE.
    - Else increment the timer (16-bit counter).
  - **DONE**
    - `req_ready[owner]=1` for exactly this cycle.
    - Set `last_grant=owner`, clear `grant`, and go to IDLE.
- Write accesses still return `dev_rdata` as sampled. Requesters ignore it.
- `req_rdata` and `req_error` hold their values until the next completion.
- A requester must drop `req_cs` in the cycle after `req_ready`. A request still held in IDLE is a new request, arbitrated with the other requesters at equal standing.

Boundary conditions:
- `req_cs` dropped mid-access: the access still completes and the `req_ready` pulse is still issued.
- `req_cs` changes on non-winners during ACCESS: ignored. Only IDLE samples requests.
- `dev_ready` in IDLE or DONE: ignored.
- `dev_ready=1` in the same cycle as the timeout condition: `dev_ready` wins, giving a normal completion with `req_error=0`.
- `TIMEOUT_CYCLES=1`: abort after exactly one ACCESS cycle without `dev_ready`.
- Reset asserted mid-access: `dev_cs`, `grant` and `req_ready` drop asynchronously and no completion is reported. After release, `last_grant=3`.

## Timing

- Cycle 0: IDLE sees `req_cs`.
- Cycle 1: `dev_cs=1` and `grant` are valid.
- If `dev_ready` arrives in cycle k (k≥1), `req_ready` is high in cycle k+1.
- Minimum latency from request to `req_ready` is 2 cycles, with `dev_ready` in cycle 1.
- Timeout: `dev_cs` is high in cycles 1..`TIMEOUT_CYCLES`, and `req_ready` with `req_error=1` is in cycle `TIMEOUT_CYCLES+1`.
- The earliest next grant is cycle k+2 (IDLE sees requests), with `dev_cs` re-asserted in k+3. Peak throughput is therefore one access per 3 cycles.
- `dev_cs` is low for at least 2 cycles between accesses.

## Test plan

- **Single read:** req 0 reads addr 8'h10 and the device acks in cycle 1 with 32'h12345678 → `dev_addr`=8'h10 and `dev_we`=0 in cycle 1, `req_ready`=4'b0001 in cycle 2, `req_rdata`=32'h12345678, `req_error`=0.
- **Round robin:** all four `req_cs` are held high, the device acks immediately, and requesters release one cycle after their ready → grant order 0,1,2,3,0, with 3-cycle grant spacing.
- **Timeout:** `TIMEOUT_CYCLES`=4, req 2 writes 32'hcafef00d and the device never acks → `dev_cs` high for cycles 1–4, `req_ready`=4'b0100 in cycle 5, `req_error`=1, `req_rdata`=32'hdeadbeef.
- **Late ack:** `TIMEOUT_CYCLES`=4 and `dev_ready` arrives in cycle 4 → normal completion with `req_error`=0 in cycle 5.
- **Requester abandons:** req 1 drops `req_cs` in cycle 2 and the device acks in cycle 3 → `req_ready`=4'b0010 in cycle 4, and no further grant to req 1.
- **Reset mid-access:** `areset` goes low in cycle 2 of an access → `dev_cs`, `grant` and `req_ready` are 0 immediately. After release, with req 0 and req 3 both requesting, req 0 is granted.
